diff_engine: RTL

DIFF_ENGINE -- requirements
Module: diff_engine

---
 rtl/diff_engine_pkg.sv | 27 ++
 rtl/diff_engine_sync.sv | 11 +
 rtl/diff_engine.sv | 122 ++++++++++++
 3 files changed

// File: rtl/diff_engine_pkg.sv
// Shared definitions for the forward-difference engine: FSM encoding and the
// power-on seed table.
package diff_engine_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArm      = 3'd1,
    StSync     = 3'd2,
    StSeed     = 3'd3,
    StCalc     = 3'd4,
    StWait     = 3'd5,
    StWaitSync = 3'd6,
    StDone     = 3'd7
  } state_e;

  // Default seeds for d[0..3]; higher indices reset to zero.
  function automatic int unsigned seed_default(input int unsigned k);
    case (k)
      0:       return 1;
      1:       return 5;
      2:       return 10;
      3:       return 6;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/diff_engine_sync.sv
// Low-then-high sequence detector: the caller says which phase it is in and
// gets back whether the input satisfies that phase this cycle.
module diff_engine_sync (
  input  logic sig,
  input  logic want_high,
  output logic hit
);

  assign hit = want_high ? sig : ~sig;

endmodule

// File: rtl/diff_engine.sv
// Forward-difference polynomial stepper: d[k] += d[k+1] each step, seeded from
// a writable seed table, stepped manually via nextn or free-running to a limit.
module diff_engine
  import diff_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned ORDER = 3,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             nextn,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  input  logic             load_en,
  input  logic [2:0]       load_idx,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] outdata,
  output logic [CNT_W-1:0] n_count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q    [0:ORDER];
  logic [WIDTH-1:0] d_d    [0:ORDER];
  logic [WIDTH-1:0] seed_q [0:ORDER];
  logic [WIDTH-1:0] seed_d [0:ORDER];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;
  logic             start_hit, nextn_hit;
  logic [WIDTH:0]   sum;

  diff_engine_sync u_start_sync (
    .sig       (start),
    .want_high (state_q == StSync),
    .hit       (start_hit)
  );

  diff_engine_sync u_nextn_sync (
    .sig       (nextn),
    .want_high (state_q == StWaitSync),
    .hit       (nextn_hit)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum     = '0;

    for (int k = 0; k <= ORDER; k++) begin
      if (load_en && load_idx == 3'(k)) seed_d[k] = load_data;
    end

    case (state_q)
      StIdle: begin
        for (int k = 0; k <= ORDER; k++) d_d[k] = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = StArm;
      end
      StArm:      if (start_hit) state_d = StSync;
      StSync:     if (start_hit) state_d = StSeed;
      StSeed: begin
        // Reads the pre-edge table, so a same-cycle load is not picked up.
        d_d     = seed_q;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = StCalc;
      end
      StCalc: begin
        for (int k = 0; k < ORDER; k++) begin
          sum    = {1'b0, d_q[k]} + {1'b0, d_q[k+1]};
          d_d[k] = sum[WIDTH-1:0];
          if (sum[WIDTH]) ovf_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (!mode)               state_d = StWait;
        else if (cnt_d == limit) state_d = StDone;
        else                     state_d = StCalc;
      end
      StWait:     if (nextn_hit) state_d = StWaitSync;
      StWaitSync: if (nextn_hit) state_d = StCalc;
      // start low here stands in for the ARM phase; SYNC then waits for high.
      StDone:     if (start_hit) state_d = StSync;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      for (int k = 0; k <= ORDER; k++) begin
        d_q[k]    <= '0;
        seed_q[k] <= WIDTH'(seed_default(k));
      end
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_q == StCalc);
    end
  end

  assign outdata  = d_q[0];
  assign n_count  = cnt_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = !(state_q inside {StIdle, StArm, StSync});

endmodule
